// File: rtl/vga_write_arbiter_pkg.sv
// Shared definitions for the VGA framebuffer write-port arbiter:
// requester indices, FSM encoding, screen bounds and small helpers.
package vga_write_arbiter_pkg;

  localparam int unsigned NUM_REQ  = 3;
  localparam int unsigned MAP      = 0;
  localparam int unsigned ANIM     = 1;
  localparam int unsigned SPR      = 2;
  localparam int unsigned X_W      = 9;
  localparam int unsigned Y_W      = 8;
  localparam int unsigned SCREEN_W = 320;
  localparam int unsigned SCREEN_H = 240;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_OWN_MAP  = 3'd1,
    ST_OWN_ANIM = 3'd2,
    ST_OWN_SPR  = 3'd3,
    ST_GAP      = 3'd4
  } arb_state_e;

  typedef struct packed {
    logic           req;
    logic           plot;
    logic           last;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pix_req_t;

  // One-hot grant {spr, anim, map} owned in a given state
  function automatic logic [NUM_REQ-1:0] state_gnt(input arb_state_e s);
    case (s)
      ST_OWN_MAP:  return 3'b001;
      ST_OWN_ANIM: return 3'b010;
      ST_OWN_SPR:  return 3'b100;
      default:     return 3'b000;
    endcase
  endfunction

  function automatic logic on_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (x < X_W'(SCREEN_W)) && (y < Y_W'(SCREEN_H));
  endfunction

endpackage

// File: rtl/vga_starve_counter.sv
// Saturating wait counter for one lower-priority requester; promoted_o is
// registered and high while the counter sits at LIMIT.
module vga_starve_counter
  import vga_write_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic req_i,
  input  logic granted_i,
  output logic promoted_o
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             promoted_q;

  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || granted_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q      <= '0;
      promoted_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      promoted_q <= (cnt_d == CNT_W'(LIMIT));
    end
  end

  assign promoted_o = promoted_q;

endmodule

// File: rtl/vga_write_arbiter.sv
// Shares the VGA framebuffer write port among map, animator and sprite
// drawers: fixed priority with starvation promotion, burst watchdog, clipping.
module vga_write_arbiter
  import vga_write_arbiter_pkg::*;
#(
  parameter int unsigned COLOUR_W     = 3,
  parameter int unsigned STARVE_LIMIT = 64,
  parameter int unsigned MAX_BURST    = 131072
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                map_req,
  input  logic                anim_req,
  input  logic                spr_req,
  input  logic                map_plot,
  input  logic                anim_plot,
  input  logic                spr_plot,
  input  logic                map_last,
  input  logic                anim_last,
  input  logic                spr_last,
  input  logic [X_W-1:0]      map_x,
  input  logic [X_W-1:0]      anim_x,
  input  logic [X_W-1:0]      spr_x,
  input  logic [Y_W-1:0]      map_y,
  input  logic [Y_W-1:0]      anim_y,
  input  logic [Y_W-1:0]      spr_y,
  input  logic [COLOUR_W-1:0] map_colour,
  input  logic [COLOUR_W-1:0] anim_colour,
  input  logic [COLOUR_W-1:0] spr_colour,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic [NUM_REQ-1:0]  timeout_flags
);

  localparam int unsigned BURST_W = $clog2(MAX_BURST);

  arb_state_e            state_q;
  arb_state_e            pick_c;
  logic [NUM_REQ-1:0]    gnt_q;
  logic [NUM_REQ-1:0]    flags_q;
  logic [BURST_W-1:0]    burst_q;
  logic                  busy_q;
  logic [X_W-1:0]        vga_x_q;
  logic [Y_W-1:0]        vga_y_q;
  logic [COLOUR_W-1:0]   vga_colour_q;
  logic                  vga_plot_q;
  logic                  anim_prom, spr_prom;
  pix_req_t              sel_c;
  logic [COLOUR_W-1:0]   sel_colour_c;
  logic                  own_c, watchdog_c, release_c;

  vga_starve_counter #(.LIMIT(STARVE_LIMIT)) u_anim_starve (
    .clock      (clock),
    .reset      (reset),
    .req_i      (anim_req),
    .granted_i  (gnt_q[ANIM]),
    .promoted_o (anim_prom)
  );

  vga_starve_counter #(.LIMIT(STARVE_LIMIT)) u_spr_starve (
    .clock      (clock),
    .reset      (reset),
    .req_i      (spr_req),
    .granted_i  (gnt_q[SPR]),
    .promoted_o (spr_prom)
  );

  // Promoted requesters first (anim over spr), then map > anim > spr
  always_comb begin
    pick_c = ST_IDLE;
    if (anim_req && anim_prom)      pick_c = ST_OWN_ANIM;
    else if (spr_req && spr_prom)   pick_c = ST_OWN_SPR;
    else if (map_req)               pick_c = ST_OWN_MAP;
    else if (anim_req)              pick_c = ST_OWN_ANIM;
    else if (spr_req)               pick_c = ST_OWN_SPR;
  end

  // Route only the current owner's pixel stream
  always_comb begin
    sel_c        = '0;
    sel_colour_c = '0;
    own_c        = 1'b0;
    case (state_q)
      ST_OWN_MAP: begin
        own_c        = 1'b1;
        sel_c        = '{req: map_req, plot: map_plot, last: map_last, x: map_x, y: map_y};
        sel_colour_c = map_colour;
      end
      ST_OWN_ANIM: begin
        own_c        = 1'b1;
        sel_c        = '{req: anim_req, plot: anim_plot, last: anim_last, x: anim_x, y: anim_y};
        sel_colour_c = anim_colour;
      end
      ST_OWN_SPR: begin
        own_c        = 1'b1;
        sel_c        = '{req: spr_req, plot: spr_plot, last: spr_last, x: spr_x, y: spr_y};
        sel_colour_c = spr_colour;
      end
      default: ;
    endcase
  end

  assign watchdog_c = own_c && (burst_q == BURST_W'(MAX_BURST - 1));
  assign release_c  = own_c && ((sel_c.plot && sel_c.last) || !sel_c.req || watchdog_c);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      gnt_q        <= '0;
      busy_q       <= 1'b0;
      burst_q      <= '0;
      flags_q      <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      // Clipped pixels still move x/y/colour but never strobe plot
      vga_plot_q <= own_c && sel_c.plot && on_screen(sel_c.x, sel_c.y);
      if (own_c && sel_c.plot) begin
        vga_x_q      <= sel_c.x;
        vga_y_q      <= sel_c.y;
        vga_colour_q <= sel_colour_c;
      end
      case (state_q)
        ST_IDLE, ST_GAP: begin
          state_q <= pick_c;
          gnt_q   <= state_gnt(pick_c);
          busy_q  <= (pick_c != ST_IDLE);
          burst_q <= '0;
        end
        ST_OWN_MAP, ST_OWN_ANIM, ST_OWN_SPR: begin
          if (release_c) begin
            state_q <= ST_GAP;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            if (watchdog_c) flags_q <= flags_q | gnt_q;
          end else begin
            burst_q <= burst_q + BURST_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt           = gnt_q;
  assign busy          = busy_q;
  assign timeout_flags = flags_q;
  assign vga_x         = vga_x_q;
  assign vga_y         = vga_y_q;
  assign vga_colour    = vga_colour_q;
  assign vga_plot      = vga_plot_q;

endmodule
